xu_lie_detect: RTL and testbench

XU_LIE_DETECT -- requirements
Module: xu_lie_detect

---
 rtl/xu_lie_pkg.sv | 15 +
 rtl/xu_lie_window.sv | 31 +++
 rtl/xu_lie_detect.sv | 117 +++++++++++
 tb/tb_xu_lie_detect.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/xu_lie_pkg.sv
// Shared constants and state encoding for the serial word-lock detector.
// Pure declarations; no logic.
// No flow control.
package xu_lie_pkg;
  localparam int WORD_W     = 10;
  localparam int CNT_W      = 4;
  localparam int LOCK_N_DEF = 3;
  localparam int MISS_N_DEF = 2;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;
endpackage

// File: rtl/xu_lie_window.sv
// Serial-to-parallel window with saturating fill counter.
// win_nxt/full are combinational on the current bit; state updates on qualified bits.
// en low freezes everything.
module xu_lie_window
  import xu_lie_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              din,
  output logic [WORD_W-1:0] win_nxt,
  output logic              full
);
  logic [WORD_W-1:0] win;
  logic [CNT_W-1:0]  fill;

  assign win_nxt = {win[WORD_W-2:0], din};
  // Full once the current bit would be the WORD_W-th valid bit.
  assign full    = (fill >= CNT_W'(WORD_W - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      win  <= '0;
      fill <= '0;
    end else if (en) begin
      win <= win_nxt;
      if (fill != CNT_W'(WORD_W))
        fill <= fill + 1'b1;
    end
  end
endmodule

// File: rtl/xu_lie_detect.sv
// Word-alignment lock detector: search, verify LOCK_N aligned hits, track MISS_N misses.
// Outputs registered, one cycle after the deciding valid bit.
// en low holds state; match/lost pulses drop low.
module xu_lie_detect
  import xu_lie_pkg::*;
#(
  parameter int LOCK_N = LOCK_N_DEF,
  parameter int MISS_N = MISS_N_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  input  logic              en,
  input  logic [WORD_W-1:0] pattern,
  output logic              match,
  output logic              locked,
  output logic              lost,
  output logic [7:0]        match_cnt
);
  state_t             state, state_nxt;
  logic [CNT_W-1:0]   phase, phase_nxt, phase_inc;
  logic [CNT_W-1:0]   hit_cnt, hit_nxt, miss_cnt, miss_nxt;
  logic               match_nxt, lost_nxt;
  logic [WORD_W-1:0]  win_nxt;
  logic               full, hit, at_cmp;

  xu_lie_window u_window (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .din     (din),
    .win_nxt (win_nxt),
    .full    (full)
  );

  assign hit       = (win_nxt == pattern);
  assign at_cmp    = (phase == CNT_W'(WORD_W - 1));
  assign phase_inc = at_cmp ? '0 : phase + 1'b1;

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    hit_nxt   = hit_cnt;
    miss_nxt  = miss_cnt;
    match_nxt = 1'b0;
    lost_nxt  = 1'b0;
    if (en) begin
      case (state)
        ST_SEARCH: begin
          if (full && hit) begin
            match_nxt = 1'b1;
            hit_nxt   = CNT_W'(1);
            phase_nxt = '0;
            state_nxt = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          phase_nxt = phase_inc;
          if (at_cmp) begin
            if (hit) begin
              match_nxt = 1'b1;
              hit_nxt   = hit_cnt + 1'b1;
              if (hit_cnt + 1'b1 == CNT_W'(LOCK_N)) begin
                state_nxt = ST_LOCKED;
                miss_nxt  = '0;
              end
            end else begin
              // Failed bit is consumed; search restarts on the next valid bit.
              state_nxt = ST_SEARCH;
              hit_nxt   = '0;
            end
          end
        end
        ST_LOCKED: begin
          phase_nxt = phase_inc;
          if (at_cmp) begin
            if (hit) begin
              match_nxt = 1'b1;
              miss_nxt  = '0;
            end else if (miss_cnt + 1'b1 == CNT_W'(MISS_N)) begin
              lost_nxt  = 1'b1;
              miss_nxt  = '0;
              hit_nxt   = '0;
              state_nxt = ST_SEARCH;
            end else begin
              miss_nxt = miss_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_SEARCH;
      phase     <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      match     <= 1'b0;
      lost      <= 1'b0;
      match_cnt <= '0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      hit_cnt  <= hit_nxt;
      miss_cnt <= miss_nxt;
      match    <= match_nxt;
      lost     <= lost_nxt;
      if (match_nxt && match_cnt != 8'hFF)
        match_cnt <= match_cnt + 1'b1;
    end
  end

  assign locked = (state == ST_LOCKED);
endmodule

// File: tb/tb_xu_lie_detect.sv
// Randomized scoreboard bench for xu_lie_detect against a bit-index reference model.
module tb_xu_lie_detect;
  localparam int LN = 3;
  localparam int MN = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       din = 1'b0;
  logic       en = 1'b0;
  logic [9:0] pattern = 10'b1100101000;
  logic       match, locked, lost;
  logic [7:0] match_cnt;

  xu_lie_detect #(.LOCK_N(LN), .MISS_N(MN)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .en        (en),
    .pattern   (pattern),
    .match     (match),
    .locked    (locked),
    .lost      (lost),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit match;
    bit locked;
    bit lost;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: absolute valid-bit index, compares at fixed index offsets.
  int         n_valid = 0;
  logic [9:0] m_last10 = '0;
  int         mode = 0;       // 0 search, 1 verify, 2 locked
  int         hits = 0;
  int         misses = 0;
  int         next_cmp = 0;
  int         mcnt = 0;

  task automatic step(input bit r, input bit e, input bit d);
    exp_t x;
    bit   h;
    @(negedge clk);
    reset = r;
    en    = e;
    din   = d;
    x.match = 0;
    x.lost  = 0;
    if (!r) begin
      n_valid = 0; m_last10 = '0; mode = 0; hits = 0; misses = 0; mcnt = 0;
    end else if (e) begin
      n_valid++;
      m_last10 = {m_last10[8:0], d};
      h = (m_last10 == pattern);
      if (mode == 0) begin
        if (n_valid >= 10 && h) begin
          x.match = 1; hits = 1; next_cmp = n_valid + 10; mode = 1;
        end
      end else if (n_valid == next_cmp) begin
        next_cmp += 10;
        if (mode == 1) begin
          if (h) begin
            x.match = 1; hits++;
            if (hits == LN) begin mode = 2; misses = 0; end
          end else begin
            mode = 0;
          end
        end else begin
          if (h) begin
            x.match = 1; misses = 0;
          end else begin
            misses++;
            if (misses == MN) begin x.lost = 1; mode = 0; end
          end
        end
      end
      if (x.match && mcnt < 255) mcnt++;
    end
    x.locked = (mode == 2);
    x.cnt    = mcnt;
    q.push_back(x);
  endtask

  task automatic send_word(input logic [9:0] w, input int gap_div);
    for (int i = 9; i >= 0; i--) begin
      if (gap_div > 0 && $urandom_range(gap_div - 1, 0) == 0) begin
        int g;
        g = $urandom_range(4, 1);
        for (int k = 0; k < g; k++) step(1, 0, 1'($urandom_range(1, 0)));
      end
      step(1, 1, w[i]);
    end
  endtask

  // Monitor: every clock the DUT presents a new output set; compare it to the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        checks += 4;
        if (match !== x.match) begin
          failures++;
          $display("FAIL match t=%0t got=%0b want=%0b", $time, match, x.match);
        end
        if (locked !== x.locked) begin
          failures++;
          $display("FAIL locked t=%0t got=%0b want=%0b", $time, locked, x.locked);
        end
        if (lost !== x.lost) begin
          failures++;
          $display("FAIL lost t=%0t got=%0b want=%0b", $time, lost, x.lost);
        end
        if (match_cnt !== 8'(x.cnt)) begin
          failures++;
          $display("FAIL match_cnt t=%0t got=%0d want=%0d", $time, match_cnt, x.cnt);
        end
      end
    end
  end

  initial begin
    logic [9:0] p;
    logic [9:0] w;
    p = 10'b1100101000;
    pattern = p;

    repeat (3) step(0, 0, 0);

    // Clean lock, one tolerated miss, then two misses drop lock and a relock.
    for (int k = 0; k < 4; k++) send_word(p, 0);
    send_word(p ^ (10'd1 << $urandom_range(9, 0)), 0);
    send_word(p, 0);
    send_word(p, 0);
    send_word(p ^ 10'($urandom_range(1023, 1)), 0);
    send_word(p ^ 10'($urandom_range(1023, 1)), 0);
    for (int k = 0; k < 5; k++) send_word(p, 0);

    // Reset while locked, then restart from an empty window.
    step(0, 1, 1'($urandom_range(1, 0)));
    for (int k = 0; k < 4; k++) send_word(p, 0);

    // Three-bit offset stream with random en gaps.
    step(0, 0, 0);
    for (int i = 2; i >= 0; i--) step(1, 1, p[i]);
    for (int k = 0; k < 6; k++) send_word(p, 3);

    // Sub-period pattern on an alternating stream.
    step(0, 0, 0);
    pattern = 10'b1010101010;
    for (int i = 0; i < 60; i++) step(1, 1, 1'(i % 2 == 0));

    // Random pattern with corrupted words, gaps and bit slips.
    step(0, 0, 0);
    pattern = 10'($urandom_range(1023, 0));
    for (int k = 0; k < 200; k++) begin
      w = pattern;
      if ($urandom_range(4, 0) == 0) w = w ^ 10'($urandom_range(1023, 1));
      if ($urandom_range(19, 0) == 0) step(1, 1, 1'($urandom_range(1, 0)));
      send_word(w, 8);
    end

    // Long clean run saturates match_cnt.
    step(0, 0, 0);
    pattern = p;
    for (int k = 0; k < 300; k++) send_word(p, 0);
    repeat (3) step(1, 0, 0);

    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
